// File: rtl/shot_controller_pkg.sv
// Shared game definitions for the shot sequencer: cell codes, FSM state
// encodings and default game limits.
package shot_controller_pkg;

    typedef enum logic [1:0] {
        CELL_WATER = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_MISS  = 2'b10,
        CELL_HIT   = 2'b11
    } cell_code_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FIRE  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SCORE = 3'd4,
        ST_DONE  = 3'd5
    } shot_state_e;

    localparam int DEFAULT_MAX_SHOTS  = 8;
    localparam int DEFAULT_SHIP_CELLS = 4;

    function automatic logic is_hit(input logic [1:0] code);
        return code == CELL_HIT;
    endfunction

endpackage

// File: rtl/shot_controller_hit_counter.sv
// Combinational popcount of HIT-coded cells; the count wraps at 4 bits.
module hit_counter
    import shot_controller_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [2*N*N-1:0] cell_state,
    output logic [3:0]       hit_count
);

    always_comb begin
        hit_count = '0;
        for (int i = 0; i < N*N; i++) begin
            if (is_hit(cell_state[2*i +: 2])) begin
                hit_count = hit_count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/shot_controller.sv
// Sequences one shot: latch selection, strobe the selected row/column, wait
// for the cells to settle, then rescan the grid to update score and result.
module shot_controller
    import shot_controller_pkg::*;
#(
    parameter int N          = 4,
    parameter int MAX_SHOTS  = DEFAULT_MAX_SHOTS,
    parameter int SHIP_CELLS = DEFAULT_SHIP_CELLS,
    parameter int SETTLE     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fire_pulse,
    input  logic [N-1:0]     sel,
    input  logic             sel_err,
    input  logic             nRow,
    input  logic [2*N*N-1:0] cell_state,
    output logic [N-1:0]     row_en,
    output logic [N-1:0]     col_en,
    output logic             fire_out,
    output logic             busy,
    output logic [3:0]       shots_left,
    output logic [3:0]       hits,
    output logic             game_over,
    output logic             win
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE - 1);

    shot_state_e  state;
    shot_state_e  state_nxt;
    logic [N-1:0] sel_q;
    logic         nrow_q;
    logic [7:0]   settle_cnt;
    logic [3:0]   hit_count;
    logic         latch_sel;
    logic         drive_en;
    logic         ship_sunk;

    hit_counter #(.N(N)) u_hit_counter (
        .cell_state (cell_state),
        .hit_count  (hit_count)
    );

    assign ship_sunk = (hit_count == 4'(SHIP_CELLS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enables are steered from the latched selection only, so live switch
    // changes cannot disturb a shot already in progress.
    always_comb begin
        state_nxt = state;
        latch_sel = 1'b0;
        drive_en  = 1'b0;
        fire_out  = 1'b0;
        busy      = 1'b0;
        row_en    = '0;
        col_en    = '0;

        case (state)
            ST_IDLE: begin
                if (fire_pulse && !sel_err && (sel != '0) && !game_over) begin
                    state_nxt = ST_ARM;
                    latch_sel = 1'b1;
                end
            end
            ST_ARM: begin
                busy      = 1'b1;
                drive_en  = 1'b1;
                state_nxt = ST_FIRE;
            end
            ST_FIRE: begin
                busy      = 1'b1;
                drive_en  = 1'b1;
                fire_out  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy     = 1'b1;
                drive_en = 1'b1;
                if (settle_cnt == 8'd0) begin
                    state_nxt = ST_SCORE;
                end
            end
            ST_SCORE: begin
                busy = 1'b1;
                if (ship_sunk || (shots_left == 4'd0)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (drive_en) begin
            if (nrow_q) begin
                col_en = sel_q;
            end else begin
                row_en = sel_q;
            end
        end
    end

    // Shot count drops on leaving FIRE so SCORE already sees the new value
    // when deciding whether the game has run out of shots.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q      <= '0;
            nrow_q     <= 1'b0;
            settle_cnt <= '0;
            shots_left <= 4'(MAX_SHOTS);
            hits       <= '0;
            game_over  <= 1'b0;
            win        <= 1'b0;
        end else begin
            if (latch_sel) begin
                sel_q  <= sel;
                nrow_q <= nRow;
            end

            if (state == ST_FIRE) begin
                settle_cnt <= SETTLE_INIT;
                if (shots_left != 4'd0) begin
                    shots_left <= shots_left - 4'd1;
                end
            end else if ((state == ST_WAIT) && (settle_cnt != 8'd0)) begin
                settle_cnt <= settle_cnt - 8'd1;
            end

            if (state == ST_SCORE) begin
                hits <= hit_count;
                if (ship_sunk) begin
                    game_over <= 1'b1;
                    win       <= 1'b1;
                end else if (shots_left == 4'd0) begin
                    game_over <= 1'b1;
                    win       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shot_controller.sv
// Scoreboard bench for shot_controller with a behavioural 4x4 cell array model.
module tb_shot_controller;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } fire_exp_t;

    typedef struct packed {
        logic [3:0] hits;
        logic [3:0] shots;
        logic       go;
        logic       win;
    } res_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fire_pulse;
    logic [3:0]  sel;
    logic        sel_err;
    logic        nRow;
    logic [31:0] cell_state;
    logic [3:0]  row_en;
    logic [3:0]  col_en;
    logic        fire_out;
    logic        busy;
    logic [3:0]  shots_left;
    logic [3:0]  hits;
    logic        game_over;
    logic        win;

    logic        load_req = 1'b0;
    logic [31:0] load_val = '0;

    fire_exp_t fire_q[$];
    res_exp_t  res_q[$];
    int        checks = 0;
    int        errors = 0;

    always #5 clk = ~clk;

    shot_controller #(
        .N(4), .MAX_SHOTS(8), .SHIP_CELLS(4), .SETTLE(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fire_pulse (fire_pulse),
        .sel        (sel),
        .sel_err    (sel_err),
        .nRow       (nRow),
        .cell_state (cell_state),
        .row_en     (row_en),
        .col_en     (col_en),
        .fire_out   (fire_out),
        .busy       (busy),
        .shots_left (shots_left),
        .hits       (hits),
        .game_over  (game_over),
        .win        (win)
    );

    // Cells struck by a fire strobe turn SHIP->HIT and WATER->MISS.
    always @(posedge clk) begin
        if (load_req) begin
            cell_state <= load_val;
        end else if (fire_out === 1'b1) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (row_en[r] || col_en[c]) begin
                        case (cell_state[2*(r*4+c) +: 2])
                            2'b00:   cell_state[2*(r*4+c) +: 2] <= 2'b10;
                            2'b01:   cell_state[2*(r*4+c) +: 2] <= 2'b11;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic prev_busy = 1'b0;
        fire_exp_t f;
        res_exp_t  r;
        forever begin
            @(negedge clk);
            if (fire_out === 1'b1) begin
                if (fire_q.size() == 0) begin
                    checkOutput("unexpected_fire_out", fire_q.size(), 1);
                end else begin
                    f = fire_q.pop_front();
                    checkOutput("fire_row_en", row_en, f.row);
                    checkOutput("fire_col_en", col_en, f.col);
                end
            end
            if (reset === 1'b0 && prev_busy === 1'b1 && busy === 1'b0) begin
                if (res_q.size() == 0) begin
                    checkOutput("unexpected_score", res_q.size(), 1);
                end else begin
                    r = res_q.pop_front();
                    checkOutput("score_hits", hits, r.hits);
                    checkOutput("score_shots_left", shots_left, r.shots);
                    checkOutput("score_game_over", game_over, r.go);
                    checkOutput("score_win", win, r.win);
                end
            end
            prev_busy = busy;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic nr, input logic err);
        @(posedge clk); #1;
        sel        = s;
        nRow       = nr;
        sel_err    = err;
        fire_pulse = 1'b1;
        @(posedge clk); #1;
        fire_pulse = 1'b0;
    endtask

    task automatic loadCells(input logic [31:0] v);
        @(posedge clk); #1;
        load_val = v;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((busy !== 1'b0 || fire_q.size() != 0 || res_q.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timeout busy=%0b fire_q=%0d res_q=%0d", name, busy, fire_q.size(), res_q.size());
        end
    endtask

    task automatic checkQuiet(input string name, input logic [3:0] shots);
        repeat (4) @(posedge clk);
        #1;
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_shots_left"}, shots_left, shots);
        checkOutput({name, "_enables"}, {row_en, col_en}, 0);
    endtask

    initial begin
        reset      = 1'b1;
        fire_pulse = 1'b0;
        sel        = '0;
        sel_err    = 1'b0;
        nRow       = 1'b0;
        load_val   = '0;
        load_req   = 1'b1;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1 load_req = 1'b0;
        checkOutput("rst_row_en", row_en, 0);
        checkOutput("rst_col_en", col_en, 0);
        checkOutput("rst_fire_out", fire_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_shots_left", shots_left, 8);
        checkOutput("rst_hits", hits, 0);
        checkOutput("rst_game_over", game_over, 0);
        checkOutput("rst_win", win, 0);
        reset = 1'b0;

        $display("[TB] invalid selections are ignored");
        applyStimulus(4'b0010, 1'b0, 1'b1);
        checkQuiet("sel_err", 4'd8);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkQuiet("sel_zero", 4'd8);

        $display("[TB] single row shot and latency");
        fire_q.push_back(fire_exp_t'{row: 4'b0010, col: 4'b0000});
        res_q.push_back(res_exp_t'{hits: 4'd0, shots: 4'd7, go: 1'b0, win: 1'b0});
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("t1_arm_fire_out", fire_out, 0);
        checkOutput("t1_arm_row_en", row_en, 4'b0010);
        checkOutput("t1_arm_busy", busy, 1);
        @(posedge clk); #1;
        checkOutput("t1_fire_out", fire_out, 1);
        sel  = 4'b0100;
        nRow = 1'b1;
        @(posedge clk); #1;
        checkOutput("t1_wait_fire_out", fire_out, 0);
        checkOutput("t1_wait_row_en", row_en, 4'b0010);
        checkOutput("t1_wait_col_en", col_en, 4'b0000);
        waitIdle("t1_idle");
        checkOutput("t1_shots_left", shots_left, 7);

        $display("[TB] fire during WAIT is dropped");
        fire_q.push_back(fire_exp_t'{row: 4'b0001, col: 4'b0000});
        res_q.push_back(res_exp_t'{hits: 4'd0, shots: 4'd6, go: 1'b0, win: 1'b0});
        applyStimulus(4'b0001, 1'b0, 1'b0);
        @(posedge clk);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        waitIdle("t5_idle");
        checkQuiet("t5_after", 4'd6);

        $display("[TB] reset during FIRE");
        fire_q.push_back(fire_exp_t'{row: 4'b0100, col: 4'b0000});
        applyStimulus(4'b0100, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("t6_fire_out", fire_out, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("t6_fire_out_cleared", fire_out, 0);
        checkOutput("t6_enables", {row_en, col_en}, 0);
        checkOutput("t6_shots_left", shots_left, 8);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_hits", hits, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] column shot sinks the ship");
        loadCells(32'h0404_0404);
        fire_q.push_back(fire_exp_t'{row: 4'b0000, col: 4'b0010});
        res_q.push_back(res_exp_t'{hits: 4'd4, shots: 4'd7, go: 1'b1, win: 1'b1});
        applyStimulus(4'b0010, 1'b1, 1'b0);
        waitIdle("t3_idle");
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkQuiet("t3_done", 4'd7);
        checkOutput("t3_game_over", game_over, 1);
        checkOutput("t3_win", win, 1);
        checkOutput("t3_hits", hits, 4);

        $display("[TB] eight misses lose the game");
        doReset();
        loadCells(32'h0000_0055);
        for (int i = 0; i < 8; i++) begin
            fire_q.push_back(fire_exp_t'{row: 4'b1000, col: 4'b0000});
            res_q.push_back(res_exp_t'{hits: 4'd0, shots: 4'(7 - i), go: (i == 7), win: 1'b0});
            applyStimulus(4'b1000, 1'b0, 1'b0);
            waitIdle("t4_idle");
        end
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkQuiet("t4_done", 4'd0);
        checkOutput("t4_game_over", game_over, 1);
        checkOutput("t4_win", win, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
